// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the register-group access arbiter.
package reg_arb_pkg;

  localparam int REQ_N       = 2;
  localparam int NREG        = 4;
  localparam int IDX_W       = 2;
  localparam int TIMEOUT_DEF = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    WAIT = 3'd3,
    RESP = 3'd4
  } state_e;

  function automatic logic [NREG-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [NREG-1:0] one_v;
    one_v = 4'b0001;
    return one_v << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input grant logic. RG_ARB_RR_EN selects round-robin (with pointer) over fixed priority.
module rr_arbiter2 (
`ifdef RG_ARB_RR_EN
  input  logic       clk,
  input  logic       rst_n,
  input  logic       advance,
`endif
  input  logic [1:0] req,
  output logic [1:0] gnt
);

`ifdef RG_ARB_RR_EN
  // ptr_r set means requester 1 was granted last, so requester 0 wins the next tie
  logic ptr_r;

  // Pointer follows the requester granted on every accepted transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= 1'b1;
    end else if (advance) begin
      ptr_r <= gnt[1];
    end
  end

  // Tie goes to the requester not granted last; a lone request passes straight through
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = ptr_r ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end
`else
  // Requester 0 always wins a tie
  always_comb begin
    gnt = 2'b00;
    if (req[0]) begin
      gnt = 2'b01;
    end else begin
      gnt = {req[1], 1'b0};
    end
  end
`endif

endmodule

// File: rtl/reg_group_arbiter.sv
// Serialises two requesters onto the 4-entry register group's write/read interface.
// Arbitration policy is set by RG_ARB_RR_EN (round-robin when defined, fixed priority otherwise).
module reg_group_arbiter
  import reg_arb_pkg::*;
#(
  parameter int DWIDTH  = 16,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_we,
  input  logic [3:0]          req_rd,
  input  logic [3:0]          req_rs,
  input  logic [2*DWIDTH-1:0] req_wdata,
  output logic [1:0]          req_ready,
  output logic [1:0]          rsp_valid,
  output logic                rsp_err,
  output logic [DWIDTH-1:0]   rsp_rd_q,
  output logic [DWIDTH-1:0]   rsp_rs_q,
  output logic [3:0]          rg_reg_en,
  output logic [1:0]          rg_rd,
  output logic [1:0]          rg_rs,
  output logic [DWIDTH-1:0]   rg_d_in,
  output logic                rg_en_in,
  input  logic [DWIDTH-1:0]   rg_rd_q,
  input  logic [DWIDTH-1:0]   rg_rs_q,
  input  logic                rg_en_out
);

  localparam logic [3:0] TIMEOUT_C = 4'(TIMEOUT);

  state_e              state_r, next_state_s;
  logic [3:0]          wait_cnt_r;
  logic [1:0]          gnt_s;
  logic                accept_s;
  logic                sel_idx_s;
  logic                sel_we_s;
  logic [1:0]          sel_rd_s, sel_rs_s;
  logic [DWIDTH-1:0]   sel_wdata_s;
  logic                gnt_idx_r;
  logic [1:0]          rd_r, rs_r;
  logic [DWIDTH-1:0]   wdata_r;
  logic [3:0]          rg_reg_en_r;
  logic                rg_en_in_r;
  logic [1:0]          rsp_valid_r;
  logic                rsp_err_r, rsp_err_s;
  logic [DWIDTH-1:0]   rsp_rd_q_r, rsp_rs_q_r, rsp_rd_s, rsp_rs_s;

  rr_arbiter2 u_arb (
`ifdef RG_ARB_RR_EN
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (accept_s),
`endif
    .req     (req_valid),
    .gnt     (gnt_s)
  );

  assign sel_idx_s   = gnt_s[1];
  assign sel_we_s    = sel_idx_s ? req_we[1]   : req_we[0];
  assign sel_rd_s    = sel_idx_s ? req_rd[3:2] : req_rd[1:0];
  assign sel_rs_s    = sel_idx_s ? req_rs[3:2] : req_rs[1:0];
  assign sel_wdata_s = sel_idx_s ? req_wdata[2*DWIDTH-1:DWIDTH] : req_wdata[DWIDTH-1:0];

  // Next-state, accept strobe and the response payload to load on entry to RESP
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    req_ready    = 2'b00;
    rsp_err_s    = 1'b0;
    rsp_rd_s     = '0;
    rsp_rs_s     = '0;
    case (state_r)
      IDLE: begin
        if (|req_valid) begin
          accept_s     = 1'b1;
          req_ready    = gnt_s;
          next_state_s = sel_we_s ? WR : RD;
        end else begin
          next_state_s = IDLE;
        end
      end
      WR: begin
        rsp_rd_s     = wdata_r;
        next_state_s = RESP;
      end
      RD: begin
        next_state_s = WAIT;
      end
      WAIT: begin
        if (rg_en_out) begin
          rsp_rd_s     = rg_rd_q;
          rsp_rs_s     = rg_rs_q;
          next_state_s = RESP;
        end else if (wait_cnt_r == TIMEOUT_C) begin
          rsp_err_s    = 1'b1;
          next_state_s = RESP;
        end else begin
          next_state_s = WAIT;
        end
      end
      RESP: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register and WAIT cycle counter (reads 1 in the first WAIT cycle)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      wait_cnt_r <= 4'd1;
    end else begin
      state_r    <= next_state_s;
      wait_cnt_r <= (state_r == WAIT) ? (wait_cnt_r + 4'd1) : 4'd1;
    end
  end

  // Latched request payload, register-group strobes and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_idx_r   <= 1'b0;
      rd_r        <= 2'd0;
      rs_r        <= 2'd0;
      wdata_r     <= '0;
      rg_reg_en_r <= 4'b0000;
      rg_en_in_r  <= 1'b0;
      rsp_valid_r <= 2'b00;
      rsp_err_r   <= 1'b0;
      rsp_rd_q_r  <= '0;
      rsp_rs_q_r  <= '0;
    end else begin
      if (accept_s) begin
        gnt_idx_r <= sel_idx_s;
        rd_r      <= sel_rd_s;
        rs_r      <= sel_rs_s;
        wdata_r   <= sel_wdata_s;
      end
      rg_reg_en_r <= (accept_s && sel_we_s) ? idx_onehot(sel_rd_s) : 4'b0000;
      rg_en_in_r  <= accept_s && !sel_we_s;
      rsp_valid_r <= (next_state_s == RESP) ? (gnt_idx_r ? 2'b10 : 2'b01) : 2'b00;
      // Response data holds between pulses
      if (next_state_s == RESP) begin
        rsp_err_r  <= rsp_err_s;
        rsp_rd_q_r <= rsp_rd_s;
        rsp_rs_q_r <= rsp_rs_s;
      end
    end
  end

  assign rg_reg_en = rg_reg_en_r;
  assign rg_en_in  = rg_en_in_r;
  assign rg_rd     = rd_r;
  assign rg_rs     = rs_r;
  assign rg_d_in   = wdata_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_rd_q  = rsp_rd_q_r;
  assign rsp_rs_q  = rsp_rs_q_r;

endmodule
